// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller definitions.
//   deb_state_e          : side-road sensor debounce states (2-bit, 00/01/10/11)
//   TLC_DEBOUNCE_CYCLES  : default debounce window, shared with the FSM/timer team
//   TLC_DRAIN_CYCLES     : default side-green cycles per vehicle drained
package tlc_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'b00,
        RISE_CHK = 2'b01,
        HIGH     = 2'b10,
        FALL_CHK = 2'b11
    } deb_state_e;

    localparam int TLC_DEBOUNCE_CYCLES = 8;
    localparam int TLC_DRAIN_CYCLES    = 10;

endpackage

// File: rtl/side_road_debounce.sv
// Side-road loop sensor front end: synchronizer chain plus debounce FSM.
// Ports:
//   clk, reset  : clock, async active-low reset
//   sensor_raw  : raw asynchronous loop-detector input
//   state       : current debounce state (HIGH = sensor accepted high)
//   arrival     : one-cycle pulse on the first cycle of an accepted rise
module side_road_debounce
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_raw,
    output deb_state_e state,
    output logic       arrival
);

    localparam int             DW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [DW-1:0]          deb_cnt;

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_ff <= '0;
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], sensor_raw};
    end

    // deb_cnt holds how many consecutive samples of the new level have been
    // seen; the change is accepted on the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LOW;
            deb_cnt <= '0;
            arrival <= 1'b0;
        end else begin
            arrival <= 1'b0;
            case (state)
                LOW: if (sync) begin
                    state   <= RISE_CHK;
                    deb_cnt <= DW'(1);
                end
                RISE_CHK: if (!sync) begin
                    state   <= LOW;
                    deb_cnt <= '0;
                end else if (deb_cnt == LAST) begin
                    state   <= HIGH;
                    deb_cnt <= '0;
                    arrival <= 1'b1;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
                HIGH: if (!sync) begin
                    state   <= FALL_CHK;
                    deb_cnt <= DW'(1);
                end
                FALL_CHK: if (sync) begin
                    state   <= HIGH;
                    deb_cnt <= '0;
                end else if (deb_cnt == LAST) begin
                    state   <= LOW;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
                default: begin
                    state   <= LOW;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/side_road_car_detect.sv
// Side-road car detector feeding the traffic-light FSM C input.
// Debounces the loop sensor, queues arriving vehicles and drains the queue
// while the side road is green.
// Ports:
//   clk, reset    : clock, async active-low reset
//   sensor_raw    : raw loop-detector input
//   sg            : side-road green from the FSM
//   c             : registered car-waiting request
//   arrival       : one-cycle pulse per accepted vehicle
//   veh_count     : queue depth
//   overflow      : sticky, an arrival hit a full queue
//   sensor_fault  : sticky stuck-sensor flag
// Optional feature macro: SIDE_ROAD_STUCK_DETECT_EN (stuck-sensor detection;
// when undefined sensor_fault is tied 0).
module side_road_car_detect
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = TLC_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 4,
    parameter int DRAIN_CYCLES    = TLC_DRAIN_CYCLES,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_raw,
    input  logic             sg,
    output logic             c,
    output logic             arrival,
    output logic [CNT_W-1:0] veh_count,
    output logic             overflow,
    output logic             sensor_fault
);

    localparam int             DCW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DLAST = DCW'(DRAIN_CYCLES - 1);

    deb_state_e       state;
    logic [DCW-1:0]   drain_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_set;
    logic             fault_next;

    side_road_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .sensor_raw(sensor_raw),
        .state     (state),
        .arrival   (arrival)
    );

    assign tick = sg && (drain_cnt == DLAST);

    // Arrival and drain tick in the same cycle cancel; overflow only counts
    // an arrival that really has nowhere to go.
    always_comb begin
        cnt_next = veh_count;
        ovf_set  = 1'b0;
        case ({arrival, tick})
            2'b10: if (&veh_count) ovf_set = 1'b1;
                   else            cnt_next = veh_count + CNT_W'(1);
            2'b01: if (veh_count != '0) cnt_next = veh_count - CNT_W'(1);
            default: ;
        endcase
    end

`ifdef SIDE_ROAD_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    logic [SW-1:0] stuck_cnt;

    // Fault latches on the STUCK_CYCLES-th consecutive HIGH cycle.
    assign fault_next = sensor_fault ||
                        (state == HIGH && stuck_cnt == SW'(STUCK_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stuck_cnt    <= '0;
            sensor_fault <= 1'b0;
        end else begin
            sensor_fault <= fault_next;
            if (state != HIGH)                    stuck_cnt <= '0;
            else if (stuck_cnt != SW'(STUCK_CYCLES)) stuck_cnt <= stuck_cnt + SW'(1);
        end
    end
`else
    localparam int unused_stuck_cycles = STUCK_CYCLES;
    logic unused_state;
    assign unused_state = ^state;
    assign fault_next   = 1'b0;
    assign sensor_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
            veh_count <= '0;
            overflow  <= 1'b0;
            c         <= 1'b0;
        end else begin
            veh_count <= cnt_next;
            overflow  <= overflow | ovf_set;
            c         <= (cnt_next != '0) | fault_next;
            if (!sg)  drain_cnt <= '0;
            else if (drain_cnt == DLAST) drain_cnt <= '0;
            else      drain_cnt <= drain_cnt + DCW'(1);
        end
    end

endmodule

// File: doc/side_road_car_detect.md
Name: side_road_car_detect

Overview:
- Conditions the raw side-road loop-sensor signal and produces the registered car-waiting request `c` consumed by the traffic-light FSM (its C input).
- Sits directly upstream of the FSM: synchronizes and debounces the sensor, counts arriving vehicles, and drains the queue while the side road shows green (`sg` fed back from the FSM).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the sensor synchronizer (minimum 2).
- DEBOUNCE_CYCLES, 8, consecutive stable synchronized samples required to accept a level change (minimum 2).
- CNT_W, 4, width of the vehicle queue counter.
- DRAIN_CYCLES, 10, `sg`-high clock cycles per vehicle removed from the queue (minimum 1).
- STUCK_CYCLES, 1000, debounced-high duration that declares the sensor stuck (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous reset, active-low (asserted at 0).
- sensor_raw  in  1  raw asynchronous loop-detector input; bouncy.
- sg  in  1  side-road-green indication from the FSM.
- c  out  1  car waiting; consumed as the FSM C input.
- arrival  out  1  one-cycle pulse per accepted vehicle.
- veh_count  out  CNT_W  current queue depth.
- overflow  out  1  sticky flag: an arrival occurred at full count.
- sensor_fault  out  1  stuck-sensor flag (tied 0 when the feature is compiled out).

Behaviour:
Reset:
- On reset=0: synchronizer chain, debounced level, debounce counter, drain counter and veh_count all clear to 0.
- Outputs c, arrival, overflow and sensor_fault are 0.
- Reset takes effect immediately, mid-operation included, and discards any queued vehicles.

Synchronizer:
- SYNC_STAGES flops; `sync` is the last stage.

Debounce FSM, states LOW, RISE_CHK, HIGH, FALL_CHK:
- LOW: sync=1 -> go to RISE_CHK, deb_cnt=1.
- RISE_CHK: sync=0 -> back to LOW, deb_cnt=0. If deb_cnt==DEBOUNCE_CYCLES-1 and sync=1 -> go to HIGH, assert arrival for exactly that next cycle. Otherwise deb_cnt++.
- HIGH: sync=0 -> go to FALL_CHK, deb_cnt=1.
- FALL_CHK: sync=1 -> back to HIGH. If deb_cnt==DEBOUNCE_CYCLES-1 and sync=0 -> go to LOW. Otherwise deb_cnt++.
- Glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- A car held on the loop produces exactly one arrival.
- Latency from the first clock edge sampling a clean raw rise to the arrival pulse is SYNC_STAGES + DEBOUNCE_CYCLES - 1 cycles.

Drain counter:
- Clears whenever sg=0.
- While sg=1 it counts 0..DRAIN_CYCLES-1. The cycle it holds DRAIN_CYCLES-1 is a drain tick, and it wraps to 0.

veh_count update, one registered update per cycle:
- arrival only: +1. At all-ones it stays at all-ones and sets overflow.
- drain tick only: -1 if veh_count>0; at 0 it stays 0.
- arrival and drain tick together: unchanged. overflow does not set because the net is 0.

Other outputs:
- c is registered: c <= (next veh_count != 0), so c reflects the count in the same cycle veh_count does.
- overflow stays set until reset.

Optional Feature:
Macro: SIDE_ROAD_STUCK_DETECT_EN.
- Defined: a stuck counter runs while the debounce state is HIGH and clears on any other state. On reaching STUCK_CYCLES it sets sensor_fault (sticky until reset) and forces c=1 regardless of veh_count, so the side road is never starved by a failed loop. Arrivals are still counted normally.
- Undefined: no stuck counter, sensor_fault is driven 0, and c depends only on veh_count.

Decomposition:
- Shared package tlc_pkg holds:
  - the debounce state enum (LOW, RISE_CHK, HIGH, FALL_CHK), 2-bit encoding 00/01/10/11;
  - the default constants TLC_DEBOUNCE_CYCLES=8 and TLC_DRAIN_CYCLES=10, so the FSM/timer team uses the same values.
- One sub-module is natural: side_road_debounce (synchronizer plus debounce FSM, producing the debounced level and arrival). The top keeps the queue and drain logic.

Test Plan:
- Reset then idle: hold sensor_raw=0 for 50 cycles -> c=0, veh_count=0, arrival never pulses, overflow=0.
- Clean car: raw rises and is held 30 cycles -> arrival pulses exactly once, 9 cycles after the sampling edge (2+8-1); veh_count=1 and c=1 on the following cycle.
- Bounce: raw toggles 1/0 every 3 cycles for 40 cycles, then stays 0 -> no arrival, veh_count=0.
- Drain: 3 cars accepted with sg=0, then sg=1 held -> veh_count goes 3->2->1->0 at sg-high cycles 10, 20, 30; c falls with the last decrement.
- Simultaneous event and saturation: pulse an arrival on the same cycle as a drain tick with veh_count=2 -> stays 2. Feed 16 cars with sg=0 -> veh_count=15, overflow=1 after the 16th arrival. Assert reset=0 mid-sequence -> all outputs 0 asynchronously.
- With SIDE_ROAD_STUCK_DETECT_EN, STUCK_CYCLES=100: hold raw=1 for 120 cycles with sg=1 until veh_count=0 -> sensor_fault=1 and c=1 from the 100th HIGH cycle onward.
